mpu401_midi_port: RTL and testbench

//  MPU-401 compatible MIDI port with built-in 8N1 serialiser/deserialiser and parametrised RX/TX FIFOs.

---
 rtl/mpu401_midi_port.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mpu401_midi_port.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mpu401_midi_port.sv
// rtl/mpu401_midi_port.sv - MPU-401 compatible MIDI port with 8N1 serialiser/deserialiser and RX/TX FIFOs
module mpu401_midi_port #(
    parameter int CLK_DIV       = 1600,
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int TX_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       address,
    input  logic       write,
    input  logic [7:0] writedata,
    input  logic       read,
    output logic [7:0] readdata,
    input  logic       cs,
    input  logic       rx,
    output logic       tx,
    output logic       irq,
    output logic       rx_overrun
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
    localparam int RXD = 2 ** RX_DEPTH_LOG2;
    localparam int TXD = 2 ** TX_DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

    logic data_rd, status_rd, data_wr, cmd_wr, flush;
    logic ack_pending, uart_mode;

    assign data_rd   = cs & read & ~address;
    assign status_rd = cs & read & address;
    assign data_wr   = cs & write & ~address;
    assign cmd_wr    = cs & write & address;
    assign flush     = cmd_wr & (writedata == 8'hFF);

    // RX FIFO
    logic [7:0]             rx_mem [RXD];
    logic [RX_DEPTH_LOG2:0] rx_wp, rx_rp;
    logic                   rx_empty, rx_full, rx_pop, rx_push, rx_lose;
    logic                   rx_done, rx_frame_ok;
    logic [7:0]             rx_shift;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[RX_DEPTH_LOG2] != rx_rp[RX_DEPTH_LOG2]) &&
                      (rx_wp[RX_DEPTH_LOG2-1:0] == rx_rp[RX_DEPTH_LOG2-1:0]);
    assign rx_pop   = data_rd & ~ack_pending & ~rx_empty;
    // A concurrent pop frees the slot, so a full FIFO still accepts the byte.
    assign rx_push  = rx_done & rx_frame_ok & (~rx_full | rx_pop) & ~flush;
    assign rx_lose  = rx_done & ~flush & (~rx_frame_ok | (rx_full & ~rx_pop));

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wp[RX_DEPTH_LOG2-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        end
    end

    // TX FIFO
    logic [7:0]             tx_mem [TXD];
    logic [TX_DEPTH_LOG2:0] tx_wp, tx_rp;
    logic                   tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0]             tx_head;
    ser_state_t             tx_state;
    logic [CW-1:0]          tx_cnt;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[TX_DEPTH_LOG2] != tx_rp[TX_DEPTH_LOG2]) &&
                      (tx_wp[TX_DEPTH_LOG2-1:0] == tx_rp[TX_DEPTH_LOG2-1:0]);
    assign tx_push  = data_wr & ~tx_full;
    assign tx_head  = tx_mem[tx_rp[TX_DEPTH_LOG2-1:0]];
    assign tx_pop   = ~tx_empty & ((tx_state == S_IDLE) ||
                                   (tx_state == S_STOP && tx_cnt == BIT_END));

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wp[TX_DEPTH_LOG2-1:0]] <= writedata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        end
    end

    // Bus registers
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata    <= 8'h00;
            ack_pending <= 1'b0;
            uart_mode   <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            if (status_rd) begin
                readdata <= {~(ack_pending | ~rx_empty), tx_full, 6'b0};
            end else if (data_rd) begin
                if (ack_pending) begin
                    readdata    <= 8'hFE;
                    ack_pending <= 1'b0;
                end else if (!rx_empty) begin
                    readdata <= rx_mem[rx_rp[RX_DEPTH_LOG2-1:0]];
                end else begin
                    readdata <= 8'hFF;
                end
            end
            if (cmd_wr) begin
                ack_pending <= ~uart_mode;
                if (writedata == 8'hFF) begin
                    uart_mode  <= 1'b0;
                    rx_overrun <= 1'b0;
                end else if (writedata == 8'h3F) begin
                    uart_mode <= 1'b1;
                end
            end
            if (rx_lose) rx_overrun <= 1'b1;
        end
    end

    assign irq = ack_pending | ~rx_empty;

    // RX deserialiser
    logic          rx_s1, rx_s2, rx_prev;
    ser_state_t    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_prev     <= 1'b1;
            rx_state    <= S_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= 3'd0;
            rx_shift    <= 8'h00;
            rx_done     <= 1'b0;
            rx_frame_ok <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_done <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s2) rx_state <= S_START;
                end
                S_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt      <= '0;
                        rx_done     <= 1'b1;
                        rx_frame_ok <= rx_s2;
                        rx_state    <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // TX serialiser; STOP chains straight into START when more data is queued.
    logic [7:0] tx_shift;
    logic [2:0] tx_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
            tx       <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    tx_cnt <= '0;
                    if (!tx_empty) begin
                        tx_shift <= tx_head;
                        tx       <= 1'b0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt   <= '0;
                        tx_bit   <= 3'd0;
                        tx       <= tx_shift[0];
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx       <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        if (!tx_empty) begin
                            tx_shift <= tx_head;
                            tx       <= 1'b0;
                            tx_state <= S_START;
                        end else begin
                            tx_state <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu401_midi_port.sv
// tb/tb_mpu401_midi_port.sv - directed self-checking bench for mpu401_midi_port
module tb_mpu401_midi_port;

    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       reset, address, write, read, cs, rx;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       tx, irq, rx_overrun;

    int errors = 0;
    int checks = 0;

    mpu401_midi_port #(.CLK_DIV(DIV), .RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata), .cs(cs),
        .rx(rx), .tx(tx), .irq(irq), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        cs = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic a, output logic [7:0] d);
        cs = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        d = readdata;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(posedge clk);
        end
        rx = stop;
        repeat (DIV) @(posedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        #1;
    endtask

    logic [7:0] d;
    logic [9:0] fr [3];
    logic       found;

    initial begin
        reset = 1'b1; address = 1'b0; write = 1'b0; read = 1'b0; cs = 1'b0;
        writedata = 8'h00; rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_readdata", 16'(readdata), 16'h00);
        check("reset_tx", 16'(tx), 16'h1);
        check("reset_irq", 16'(irq), 16'h0);
        check("reset_overrun", 16'(rx_overrun), 16'h0);
        bus_read(1'b1, d); check("reset_status", 16'(d), 16'h80);

        // Enter UART mode: acknowledged once
        bus_write(1'b1, 8'h3F);
        bus_read(1'b1, d); check("ack_status", 16'(d), 16'h00);
        check("ack_irq", 16'(irq), 16'h1);
        bus_read(1'b0, d); check("ack_data", 16'(d), 16'hFE);
        bus_read(1'b1, d); check("ack_cleared_status", 16'(d), 16'h80);
        check("ack_cleared_irq", 16'(irq), 16'h0);

        // In UART mode the reset command itself is not acknowledged
        bus_write(1'b1, 8'hFF);
        bus_read(1'b1, d); check("uart_ff_noack", 16'(d), 16'h80);
        bus_write(1'b1, 8'hFF);
        bus_read(1'b1, d); check("second_ff_status", 16'(d), 16'h00);
        bus_read(1'b0, d); check("second_ff_ack", 16'(d), 16'hFE);
        bus_read(1'b0, d); check("empty_read", 16'(d), 16'hFF);

        // Three back-to-back TX frames, sampled mid-bit
        found = 1'b0;
        fork
            begin
                bus_write(1'b0, 8'h90);
                bus_write(1'b0, 8'h3C);
                bus_write(1'b0, 8'h7F);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk); #1;
                    if (tx === 1'b0) begin
                        found = 1'b1;
                        break;
                    end
                end
                if (found) begin
                    repeat (DIV / 2 - 1) @(posedge clk);
                    #1;
                    for (int f = 0; f < 3; f++) begin
                        for (int b = 0; b < 10; b++) begin
                            if (f != 0 || b != 0) begin
                                repeat (DIV) @(posedge clk);
                                #1;
                            end
                            fr[f][b] = tx;
                        end
                    end
                end
            end
        join
        check("tx_start_seen", 16'(found), 16'h1);
        check("tx_frame0", 16'(fr[0]), 16'({1'b1, 8'h90, 1'b0}));
        check("tx_frame1", 16'(fr[1]), 16'({1'b1, 8'h3C, 1'b0}));
        check("tx_frame2", 16'(fr[2]), 16'({1'b1, 8'h7F, 1'b0}));
        repeat (2 * DIV) @(posedge clk);
        #1 check("tx_idle", 16'(tx), 16'h1);

        // RX: one byte more than the FIFO holds
        for (int i = 0; i < 17; i++) send_rx(8'(8'h10 + 8'(i * 13)), 1'b1);
        check("rx_full_overrun", 16'(rx_overrun), 16'h1);
        check("rx_full_irq", 16'(irq), 16'h1);
        bus_read(1'b1, d); check("rx_full_status", 16'(d), 16'h00);
        for (int i = 0; i < 16; i++) begin
            bus_read(1'b0, d);
            check($sformatf("rx_byte%0d", i), 16'(d), 16'(8'(8'h10 + 8'(i * 13))));
        end
        bus_read(1'b0, d); check("rx_drained", 16'(d), 16'hFF);

        // Reset command clears overrun and acknowledges
        bus_write(1'b1, 8'hFF);
        check("flush_overrun", 16'(rx_overrun), 16'h0);
        bus_read(1'b0, d); check("flush_ack", 16'(d), 16'hFE);
        bus_read(1'b0, d); check("flush_empty", 16'(d), 16'hFF);

        // Framing error
        send_rx(8'h55, 1'b0);
        check("frame_err_overrun", 16'(rx_overrun), 16'h1);
        check("frame_err_irq", 16'(irq), 16'h0);
        bus_read(1'b0, d); check("frame_err_nopush", 16'(d), 16'hFF);

        // Ack is returned ahead of queued RX data
        bus_write(1'b1, 8'h00);
        send_rx(8'hA5, 1'b1);
        bus_read(1'b0, d); check("ack_before_data", 16'(d), 16'hFE);
        bus_read(1'b0, d); check("data_after_ack", 16'(d), 16'hA5);

        // Reset in the middle of a TX data bit
        bus_write(1'b1, 8'h00);
        bus_write(1'b0, 8'h00);
        repeat (14) @(posedge clk);
        #1;
        check("pre_reset_tx_data", 16'(tx), 16'h0);
        check("pre_reset_irq", 16'(irq), 16'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_tx", 16'(tx), 16'h1);
        check("midreset_irq", 16'(irq), 16'h0);
        check("midreset_readdata", 16'(readdata), 16'h00);
        check("midreset_overrun", 16'(rx_overrun), 16'h0);
        reset = 1'b0;
        bus_read(1'b1, d); check("midreset_status", 16'(d), 16'h80);
        repeat (3 * DIV) @(posedge clk);
        #1 check("midreset_tx_stays_idle", 16'(tx), 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
